rr_arbiter: RTL and testbench
=============================

RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 6, number of requesters sharing the mux-selected resource (2..16).
REQ-002 SHALL have parameter MAX_HOLD, default 8, maximum consecutive grant cycles per owner when the timeout feature is compiled in (>=2).
REQ-003 SHALL have port i_clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port i_rst_n, input, 1, reset; asynchronous assert, active-low.
REQ-005 SHALL have port i_req, input, NUM_REQ, per-requester request level; bit k high = requester k wants the resource.
REQ-006 SHALL have port o_grant, output, NUM_REQ, one-hot registered grant; all-zero when idle.
REQ-007 SHALL have port o_select, output, $clog2(NUM_REQ), binary index of the owner; drives the shared mux select input.
REQ-008 SHALL have port o_valid, output, 1, high while any grant is held; o_select is meaningful only when high.

Function
REQ-009 SHALL implement two states: IDLE (no owner) and GRANT (one owner held in a register).
REQ-010 IDLE: if any i_req bit is high at an edge, the state SHALL move to GRANT with the winner registered; o_grant/o_valid rise one cycle after the request.
REQ-011 The winner SHALL be the first requesting index scanning circularly from (last_owner+1) mod NUM_REQ.
REQ-012 GRANT: while i_req[owner] stays high (and no timeout), owner, o_grant and o_select SHALL hold unchanged.
REQ-013 GRANT: when i_req[owner] is low at an edge, the arbiter SHALL pick a new winner from the other requesters at that edge (zero-bubble handoff) or return to IDLE if none.
REQ-014 last_owner SHALL update on every new grant; it wraps from NUM_REQ-1 to 0.
REQ-015 o_grant SHALL always be zero or one-hot and consistent with o_select and o_valid; o_grant is never driven from i_req combinationally.
REQ-016 In IDLE, o_select SHALL be 0, o_grant 0 and o_valid 0.
REQ-017 Requests on indices >= NUM_REQ SHALL NOT exist (i_req is exactly NUM_REQ wide); o_select SHALL never exceed NUM_REQ-1.

Reset
REQ-018 Asserting i_rst_n low SHALL immediately force IDLE, o_grant=0, o_select=0 and o_valid=0, including mid-grant.
REQ-019 Reset SHALL set last_owner to NUM_REQ-1 so requester 0 has top priority on the first arbitration.
REQ-020 Reset SHALL clear the hold counter (when present).

Configuration
REQ-021 Macro RR_ARBITER_TIMEOUT_EN SHALL compile in a hold counter, cleared on each new grant and incremented every GRANT cycle.
REQ-022 With RR_ARBITER_TIMEOUT_EN: when the counter equals MAX_HOLD-1 and any other i_req bit is high, the owner SHALL be revoked at that edge and the next circular winner granted; if no other request exists, the owner keeps the grant and the counter saturates.
REQ-023 Without RR_ARBITER_TIMEOUT_EN: no counter SHALL exist; an owner holds indefinitely and MAX_HOLD is ignored.

Structure
REQ-024 Package arb_pkg SHALL hold the state enum (ARB_IDLE, ARB_GRANT) and the select-width helper constant.
REQ-025 A combinational sub-module rr_priority_pick SHALL compute the circular first-set index and a found flag from a request vector, a start pointer and an exclude mask.
REQ-026 rr_arbiter SHALL contain the state register, owner, last_owner and optional counter; target size 120-400 RTL lines.

Verification (NUM_REQ=6, MAX_HOLD=4)
REQ-027 After reset, i_req=6'b000101 -> next cycle o_grant=6'b000001, o_select=0, o_valid=1.
REQ-028 Owner 0 drops request with i_req=6'b000100 -> same edge hands off; next cycle o_select=2, no idle cycle between.
REQ-029 last_owner=5, i_req=6'b100001 -> grant goes to 0 (wrap), then to 5 after 0 releases.
REQ-030 Reset pulse while o_select=3 -> o_valid=0, o_grant=0 asynchronously, before the next clock edge.
REQ-031 With RR_ARBITER_TIMEOUT_EN, i_req=6'b000011 held -> owner 0 for 4 cycles, then owner 1 for 4, then 0; with only bit 0 set, owner 0 is kept beyond 4 cycles.
REQ-032 All scenarios -> assert o_grant is zero or one-hot and equals 1<<o_select whenever o_valid=1.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin arbiter.
// Holds the FSM state enum and the select-width helper.
package arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  localparam int ARB_MAX_REQ   = 16;
  localparam int ARB_SEL_W_MAX = $clog2(ARB_MAX_REQ);

  // Select width for n requesters (never below one bit).
  function automatic int arb_sel_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Circular first-set finder: scans i_req & ~i_excl from i_start.
// Ports: i_req, i_start, i_excl in; o_idx, o_found out.
module rr_priority_pick
  import arb_pkg::*;
#(
  parameter int N = 6,
  parameter int W = arb_sel_w(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_start,
  input  logic [N-1:0] i_excl,
  output logic [W-1:0] o_idx,
  output logic         o_found
);

  logic [N-1:0] w_mask;
  int           w_k;

  always_comb begin
    w_mask  = i_req & ~i_excl;
    o_idx   = '0;
    o_found = 1'b0;
    w_k     = 0;
    for (int i = 0; i < N; i++) begin
      // wrap the scan position without a modulo operator
      w_k = int'(i_start) + i;
      if (w_k >= N) w_k = w_k - N;
      if (!o_found && w_mask[w_k]) begin
        o_found = 1'b1;
        o_idx   = W'(w_k);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant and mux select.
// Ports: i_clk, i_rst_n, i_req in; o_grant, o_select, o_valid out.
// Macro RR_ARBITER_TIMEOUT_EN adds a MAX_HOLD-cycle hold limit.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = 6,
  parameter int MAX_HOLD = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_REQ-1:0]         i_req,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_select,
  output logic                       o_valid
);

  localparam int W = arb_sel_w(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
  localparam logic [W-1:0] LAST_IDX = W'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > ARB_MAX_REQ || MAX_HOLD < 2)
  begin : g_bad_cfg
    $error("rr_arbiter: parameter out of range");
  end

  arb_state_e         r_state;
  logic [W-1:0]       r_owner;
  logic [W-1:0]       r_last;
  logic [NUM_REQ-1:0] r_grant;

  logic [W-1:0]       w_start;
  logic [NUM_REQ-1:0] w_excl;
  logic [W-1:0]       w_idx;
  logic               w_found;
  logic               w_tmo;
  logic               w_switch;
  logic               w_take;

  assign w_start = (r_last == LAST_IDX) ? '0 : r_last + 1'b1;

  // the owner never competes against itself at a handoff/revoke
  assign w_excl = (r_state == ARB_GRANT) ? (ONE << r_owner) : '0;

  rr_priority_pick #(
    .N (NUM_REQ),
    .W (W)
  ) u_pick (
    .i_req   (i_req),
    .i_start (w_start),
    .i_excl  (w_excl),
    .o_idx   (w_idx),
    .o_found (w_found)
  );

`ifdef RR_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  logic [CW-1:0] r_cnt;

  assign w_tmo = (r_cnt == HOLD_LAST);

  // saturates at HOLD_LAST when nobody else is waiting
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_take) begin
      r_cnt <= '0;
    end else if (r_state == ARB_GRANT && !w_tmo) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  assign w_switch = (r_state == ARB_GRANT) &&
                    (!i_req[r_owner] || (w_tmo && w_found));
  assign w_take   = w_found &&
                    ((r_state == ARB_IDLE) || w_switch);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ARB_IDLE;
      r_owner <= '0;
      r_last  <= LAST_IDX;
      r_grant <= '0;
    end else begin
      unique case (r_state)
        ARB_IDLE: begin
          if (w_found) begin
            r_state <= ARB_GRANT;
            r_owner <= w_idx;
            r_last  <= w_idx;
            r_grant <= ONE << w_idx;
          end
        end
        ARB_GRANT: begin
          if (w_switch) begin
            if (w_found) begin
              r_owner <= w_idx;
              r_last  <= w_idx;
              r_grant <= ONE << w_idx;
            end else begin
              r_state <= ARB_IDLE;
              r_owner <= '0;
              r_grant <= '0;
            end
          end
        end
        default: begin
          r_state <= ARB_IDLE;
          r_owner <= '0;
          r_grant <= '0;
        end
      endcase
    end
  end

  assign o_grant  = r_grant;
  assign o_select = r_owner;
  assign o_valid  = (r_state == ARB_GRANT);

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed self-checking bench for rr_arbiter (NUM_REQ=6, MAX_HOLD=4).
// Timeout scenario runs only when RR_ARBITER_TIMEOUT_EN is defined.
module tb_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [5:0] i_req;
  logic [5:0] o_grant;
  logic [2:0] o_select;
  logic       o_valid;

  int vec;
  int miss;

  rr_arbiter #(
    .NUM_REQ  (6),
    .MAX_HOLD (4)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_req    (i_req),
    .o_grant  (o_grant),
    .o_select (o_select),
    .o_valid  (o_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    i_req = 6'b111111;
    repeat (2) @(posedge clk);
    #1;
    vec++;
    if ({o_valid, o_select, o_grant} !== 10'b0) begin
      miss++;
      $display("FAIL reset got v=%b s=%0d g=%b exp all zero",
               o_valid, o_select, o_grant);
    end
    i_req = 6'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_first_grant();
    logic [5:0] rq [3] = '{6'b000101, 6'b000100, 6'b000000};
    logic [2:0] es [3] = '{3'd0, 3'd2, 3'd0};
    logic       ev [3] = '{1'b1, 1'b1, 1'b0};
    logic [5:0] eg;
    for (int k = 0; k < 3; k++) begin
      i_req = rq[k];
      @(posedge clk); #1;
      eg = ev[k] ? (6'b1 << es[k]) : 6'b0;
      vec++;
      if ({o_valid, o_select, o_grant} !== {ev[k], es[k], eg}) begin
        miss++;
        $display("FAIL first_handoff[%0d] got v=%b s=%0d g=%b exp v=%b s=%0d g=%b",
                 k, o_valid, o_select, o_grant, ev[k], es[k], eg);
      end
    end
  endtask

  task automatic test_wrap();
    logic [5:0] rq [5] = '{6'b100000, 6'b000000, 6'b100001,
                           6'b100000, 6'b000000};
    logic [2:0] es [5] = '{3'd5, 3'd0, 3'd0, 3'd5, 3'd0};
    logic       ev [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [5:0] eg;
    for (int k = 0; k < 5; k++) begin
      i_req = rq[k];
      @(posedge clk); #1;
      eg = ev[k] ? (6'b1 << es[k]) : 6'b0;
      vec++;
      if ({o_valid, o_select, o_grant} !== {ev[k], es[k], eg}) begin
        miss++;
        $display("FAIL wrap[%0d] got v=%b s=%0d g=%b exp v=%b s=%0d g=%b",
                 k, o_valid, o_select, o_grant, ev[k], es[k], eg);
      end
    end
  endtask

  task automatic test_hold_rotate();
    logic [5:0] rq [6] = '{6'b111111, 6'b111111, 6'b111111,
                           6'b111110, 6'b101100, 6'b101000};
    logic [2:0] es [6] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3};
    logic [5:0] eg;
    for (int k = 0; k < 6; k++) begin
      i_req = rq[k];
      @(posedge clk); #1;
      eg = 6'b1 << es[k];
      vec++;
      if ({o_valid, o_select, o_grant} !== {1'b1, es[k], eg}) begin
        miss++;
        $display("FAIL hold_rotate[%0d] got v=%b s=%0d g=%b exp v=1 s=%0d g=%b",
                 k, o_valid, o_select, o_grant, es[k], eg);
      end
    end
  endtask

  task automatic test_async_reset();
    #2;
    vec++;
    if ({o_valid, o_select, o_grant} !== {1'b1, 3'd3, 6'b001000}) begin
      miss++;
      $display("FAIL pre_reset got v=%b s=%0d g=%b exp v=1 s=3 g=001000",
               o_valid, o_select, o_grant);
    end
    rst_n = 1'b0;
    #1;
    vec++;
    if ({o_valid, o_select, o_grant} !== 10'b0) begin
      miss++;
      $display("FAIL async_reset got v=%b s=%0d g=%b exp all zero",
               o_valid, o_select, o_grant);
    end
    i_req = 6'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset_priority();
    logic [5:0] rq [3] = '{6'b000110, 6'b001100, 6'b000000};
    logic [2:0] es [3] = '{3'd1, 3'd2, 3'd0};
    logic       ev [3] = '{1'b1, 1'b1, 1'b0};
    logic [5:0] eg;
    for (int k = 0; k < 3; k++) begin
      i_req = rq[k];
      @(posedge clk); #1;
      eg = ev[k] ? (6'b1 << es[k]) : 6'b0;
      vec++;
      if ({o_valid, o_select, o_grant} !== {ev[k], es[k], eg}) begin
        miss++;
        $display("FAIL reset_prio[%0d] got v=%b s=%0d g=%b exp v=%b s=%0d g=%b",
                 k, o_valid, o_select, o_grant, ev[k], es[k], eg);
      end
    end
  endtask

`ifdef RR_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    logic [2:0] es;
    logic [5:0] eg;
    for (int k = 0; k < 18; k++) begin
      i_req = (k < 12) ? 6'b000011 : 6'b000001;
      @(posedge clk); #1;
      es = (k >= 4 && k < 8) ? 3'd1 : 3'd0;
      eg = 6'b1 << es;
      vec++;
      if ({o_valid, o_select, o_grant} !== {1'b1, es, eg}) begin
        miss++;
        $display("FAIL timeout[%0d] got v=%b s=%0d g=%b exp v=1 s=%0d g=%b",
                 k, o_valid, o_select, o_grant, es, eg);
      end
    end
    i_req = 6'b0;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    vec  = 0;
    miss = 0;
    test_reset();
    test_first_grant();
    test_wrap();
    test_hold_rotate();
    test_async_reset();
    test_reset_priority();
`ifdef RR_ARBITER_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
